// File: rtl/rs_alu_station_if.sv
// rtl/rs_alu_station_if.sv - dispatch, CDB snoop and issue bundle of the ALU reservation station
interface rs_alu_station_if #(
    parameter int TAG_W = 4,
    parameter int XLEN  = 32,
    parameter int OP_W  = 6,
    parameter int NCDB  = 2
) ();
    logic                   disp_valid;
    logic                   disp_ready;
    logic [OP_W-1:0]        disp_op;
    logic                   disp_rj;
    logic                   disp_rk;
    logic [XLEN-1:0]        disp_vj;
    logic [XLEN-1:0]        disp_vk;
    logic                   disp_use_imm;
    logic [XLEN-1:0]        disp_imm;
    logic [TAG_W-1:0]       disp_tag;
    logic [NCDB-1:0]        cdb_valid;
    logic [NCDB*TAG_W-1:0]  cdb_tag;
    logic [NCDB*XLEN-1:0]   cdb_val;
    logic                   issue_valid;
    logic                   issue_ready;
    logic [OP_W-1:0]        issue_op;
    logic [XLEN-1:0]        issue_vj;
    logic [XLEN-1:0]        issue_vk;
    logic [XLEN-1:0]        issue_imm;
    logic [TAG_W-1:0]       issue_tag;

    modport master (
        output disp_valid, disp_op, disp_rj, disp_rk, disp_vj, disp_vk,
               disp_use_imm, disp_imm, disp_tag,
               cdb_valid, cdb_tag, cdb_val, issue_ready,
        input  disp_ready, issue_valid, issue_op, issue_vj, issue_vk,
               issue_imm, issue_tag
    );

    modport slave (
        input  disp_valid, disp_op, disp_rj, disp_rk, disp_vj, disp_vk,
               disp_use_imm, disp_imm, disp_tag,
               cdb_valid, cdb_tag, cdb_val, issue_ready,
        output disp_ready, issue_valid, issue_op, issue_vj, issue_vk,
               issue_imm, issue_tag
    );
endinterface

// File: rtl/rs_alu_station.sv
// rtl/rs_alu_station.sv - ALU reservation station with CDB wakeup and registered issue stage
// Optional RS_CDB_BYPASS_EN: dispatch-cycle CDB match captures the broadcast value directly.
module rs_alu_station #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4,
    parameter int XLEN  = 32,
    parameter int OP_W  = 6,
    parameter int NCDB  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_rdy,
    input  logic                         i_flush,
    rs_alu_station_if.slave              bus,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]   r_busy;
    logic [DEPTH-1:0]   r_rj;
    logic [DEPTH-1:0]   r_rk;
    logic [OP_W-1:0]    r_op  [DEPTH];
    logic [XLEN-1:0]    r_vj  [DEPTH];
    logic [XLEN-1:0]    r_vk  [DEPTH];
    logic [XLEN-1:0]    r_imm [DEPTH];
    logic [TAG_W-1:0]   r_tag [DEPTH];

    logic               r_issue_valid;
    logic [OP_W-1:0]    r_issue_op;
    logic [XLEN-1:0]    r_issue_vj;
    logic [XLEN-1:0]    r_issue_vk;
    logic [XLEN-1:0]    r_issue_imm;
    logic [TAG_W-1:0]   r_issue_tag;

    logic [CNT_W-1:0]   w_count;
    logic               w_disp_ready;
    logic               w_disp_fire;
    logic [IDX_W-1:0]   w_free_idx;
    logic [DEPTH-1:0]   w_ready;
    logic               w_sel_any;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_issue_load;
    logic [DEPTH-1:0]   w_wj_hit;
    logic [DEPTH-1:0]   w_wk_hit;
    logic [XLEN-1:0]    w_wj_val [DEPTH];
    logic [XLEN-1:0]    w_wk_val [DEPTH];
    logic               w_d_rj;
    logic               w_d_rk;
    logic [XLEN-1:0]    w_d_vj;
    logic [XLEN-1:0]    w_d_vk;

    always_comb begin
        w_count = '0;
        for (int e = 0; e < DEPTH; e++) begin
            w_count = w_count + CNT_W'(r_busy[e]);
        end
    end

    assign w_disp_ready = (w_count < CNT_W'(DEPTH));
    assign w_disp_fire  = bus.disp_valid & w_disp_ready;
    assign w_ready      = r_busy & r_rj & r_rk;

    // Descending scans so the last assignment leaves the lowest matching index.
    always_comb begin
        w_free_idx = '0;
        for (int e = DEPTH-1; e >= 0; e--) begin
            if (!r_busy[e]) begin
                w_free_idx = IDX_W'(e);
            end
        end
    end

    always_comb begin
        w_sel_idx = '0;
        w_sel_any = 1'b0;
        for (int e = DEPTH-1; e >= 0; e--) begin
            if (w_ready[e]) begin
                w_sel_idx = IDX_W'(e);
                w_sel_any = 1'b1;
            end
        end
    end

    assign w_issue_load = (!r_issue_valid | bus.issue_ready) & w_sel_any;

    always_comb begin
        w_wj_hit = '0;
        w_wk_hit = '0;
        for (int e = 0; e < DEPTH; e++) begin
            w_wj_val[e] = '0;
            w_wk_val[e] = '0;
            for (int c = NCDB-1; c >= 0; c--) begin
                if (bus.cdb_valid[c] && (bus.cdb_tag[c*TAG_W +: TAG_W] == r_vj[e][TAG_W-1:0])) begin
                    w_wj_hit[e] = 1'b1;
                    w_wj_val[e] = bus.cdb_val[c*XLEN +: XLEN];
                end
                if (bus.cdb_valid[c] && (bus.cdb_tag[c*TAG_W +: TAG_W] == r_vk[e][TAG_W-1:0])) begin
                    w_wk_hit[e] = 1'b1;
                    w_wk_val[e] = bus.cdb_val[c*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        w_d_rj = bus.disp_rj;
        w_d_vj = bus.disp_vj;
        w_d_rk = bus.disp_rk | bus.disp_use_imm;
        w_d_vk = bus.disp_use_imm ? '0 : bus.disp_vk;
`ifdef RS_CDB_BYPASS_EN
        for (int c = NCDB-1; c >= 0; c--) begin
            if (!bus.disp_rj && bus.cdb_valid[c] &&
                (bus.cdb_tag[c*TAG_W +: TAG_W] == bus.disp_vj[TAG_W-1:0])) begin
                w_d_rj = 1'b1;
                w_d_vj = bus.cdb_val[c*XLEN +: XLEN];
            end
            if (!bus.disp_rk && !bus.disp_use_imm && bus.cdb_valid[c] &&
                (bus.cdb_tag[c*TAG_W +: TAG_W] == bus.disp_vk[TAG_W-1:0])) begin
                w_d_rk = 1'b1;
                w_d_vk = bus.cdb_val[c*XLEN +: XLEN];
            end
        end
`endif
    end

    // Wakeup only touches busy entries and dispatch only a free one, so they never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_rj   <= '0;
            r_rk   <= '0;
        end else if (i_rdy) begin
            if (i_flush) begin
                r_busy <= '0;
            end else begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (r_busy[e] && !r_rj[e] && w_wj_hit[e]) begin
                        r_rj[e] <= 1'b1;
                        r_vj[e] <= w_wj_val[e];
                    end
                    if (r_busy[e] && !r_rk[e] && w_wk_hit[e]) begin
                        r_rk[e] <= 1'b1;
                        r_vk[e] <= w_wk_val[e];
                    end
                end
                if (w_issue_load) begin
                    r_busy[w_sel_idx] <= 1'b0;
                end
                if (w_disp_fire) begin
                    r_busy[w_free_idx] <= 1'b1;
                    r_rj[w_free_idx]   <= w_d_rj;
                    r_rk[w_free_idx]   <= w_d_rk;
                    r_vj[w_free_idx]   <= w_d_vj;
                    r_vk[w_free_idx]   <= w_d_vk;
                    r_op[w_free_idx]   <= bus.disp_op;
                    r_imm[w_free_idx]  <= bus.disp_imm;
                    r_tag[w_free_idx]  <= bus.disp_tag;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_valid <= 1'b0;
            r_issue_op    <= '0;
            r_issue_vj    <= '0;
            r_issue_vk    <= '0;
            r_issue_imm   <= '0;
            r_issue_tag   <= '0;
        end else if (i_rdy) begin
            if (i_flush) begin
                r_issue_valid <= 1'b0;
            end else if (w_issue_load) begin
                r_issue_valid <= 1'b1;
                r_issue_op    <= r_op[w_sel_idx];
                r_issue_vj    <= r_vj[w_sel_idx];
                r_issue_vk    <= r_vk[w_sel_idx];
                r_issue_imm   <= r_imm[w_sel_idx];
                r_issue_tag   <= r_tag[w_sel_idx];
            end else if (bus.issue_ready) begin
                r_issue_valid <= 1'b0;
            end
        end
    end

    assign bus.disp_ready  = w_disp_ready;
    assign bus.issue_valid = r_issue_valid;
    assign bus.issue_op    = r_issue_op;
    assign bus.issue_vj    = r_issue_vj;
    assign bus.issue_vk    = r_issue_vk;
    assign bus.issue_imm   = r_issue_imm;
    assign bus.issue_tag   = r_issue_tag;
    assign o_count         = w_count;
endmodule
